// File: rtl/rle_stream_arbiter.sv
// rle_stream_arbiter
//   Merges the two RLE channel streams (ch0 = approximation, ch1 = detail)
//   onto one tagged valid/ready link. Each channel has its own small FIFO.
//   A round-robin arbiter drains the FIFOs into a registered output stage.
//   Output word: {ch_id, value, count}, with ch_id in the MSB.
//   Optional build macro RLE_ARB_STATS_EN adds per-channel saturating
//   counters for emitted words and dropped pushes.
module rle_stream_arbiter #(
   parameter int DEPTH = 4,
   parameter int VW    = 9,
   parameter int CW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VW-1:0]        ch0_value,
   input  logic [CW-1:0]        ch0_count,
   input  logic                 ch0_valid,
   input  logic [VW-1:0]        ch1_value,
   input  logic [CW-1:0]        ch1_count,
   input  logic                 ch1_valid,
   output logic [VW+CW:0]       out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           ch_full,
   output logic [1:0]           ovf,
`ifdef RLE_ARB_STATS_EN
   output logic [15:0]          stat_words0,
   output logic [15:0]          stat_words1,
   output logic [15:0]          stat_drops0,
   output logic [15:0]          stat_drops1,
`endif
   input  logic                 clr_ovf
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int EW   = VW + CW;

   typedef enum logic {G0 = 1'b0, G1 = 1'b1} grant_t;

   // FIFO storage and bookkeeping, indexed by channel
   logic [EW-1:0]   r_mem    [2][DEPTH];
   logic [AW-1:0]   r_wr_ptr [2];
   logic [AW-1:0]   r_rd_ptr [2];
   logic [CNTW-1:0] r_count  [2];

   logic [VW+CW:0]  r_out_data;
   logic            r_out_valid;
   logic [1:0]      r_ovf;
   grant_t          r_last_grant;
   grant_t          w_next_grant;

   logic [EW-1:0]   w_in_word [2];
   logic [1:0]      w_in_valid;
   logic [1:0]      w_nempty;
   logic [1:0]      w_full;
   logic [1:0]      w_pop;
   logic [1:0]      w_push;
   logic [1:0]      w_drop;
   logic            w_load_en;
   logic            w_grant;
   logic            w_pop_any;

   assign w_in_word[0] = {ch0_value, ch0_count};
   assign w_in_word[1] = {ch1_value, ch1_count};
   assign w_in_valid   = {ch1_valid, ch0_valid};

   // Occupancy-derived status flags
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         w_nempty[n] = (r_count[n] != CNTW'(0));
         w_full[n]   = (r_count[n] == CNTW'(DEPTH));
      end
   end

   assign w_load_en = !r_out_valid || out_ready;
   assign w_pop_any = w_load_en && (|w_nempty);

   // Round-robin grant: alternate when both channels have data
   always_comb begin
      w_grant = 1'b0;
      if (w_nempty[0] && w_nempty[1]) begin
         w_grant = (r_last_grant == G0) ? 1'b1 : 1'b0;
      end else if (w_nempty[1]) begin
         w_grant = 1'b1;
      end else begin
         w_grant = 1'b0;
      end
   end

   // Pop/push/drop decisions; a full FIFO still accepts when popped this cycle
   always_comb begin
      w_pop  = 2'b00;
      w_push = 2'b00;
      w_drop = 2'b00;
      for (int n = 0; n < 2; n++) begin
         w_pop[n]  = w_pop_any && (w_grant == n[0]);
         w_push[n] = w_in_valid[n] && (!w_full[n] || w_pop[n]);
         w_drop[n] = w_in_valid[n] && !w_push[n];
      end
   end

   // Arbiter next state: last_grant moves only on an actual pop
   always_comb begin
      w_next_grant = r_last_grant;
      if (w_pop_any) begin
         w_next_grant = w_grant ? G1 : G0;
      end else begin
         w_next_grant = r_last_grant;
      end
   end

   // Arbiter state register; after reset channel 0 wins first
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= G1;
      end else begin
         r_last_grant <= w_next_grant;
      end
   end

   // FIFO storage writes (contents need no reset; pointers gate visibility)
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (!rst && w_push[n]) begin
            r_mem[n][r_wr_ptr[n]] <= w_in_word[n];
         end
      end
   end

   // FIFO pointers and occupancy counters
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (rst) begin
            r_wr_ptr[n] <= AW'(0);
            r_rd_ptr[n] <= AW'(0);
            r_count[n]  <= CNTW'(0);
         end else begin
            if (w_push[n]) begin
               r_wr_ptr[n] <= r_wr_ptr[n] + AW'(1);
            end
            if (w_pop[n]) begin
               r_rd_ptr[n] <= r_rd_ptr[n] + AW'(1);
            end
            case ({w_push[n], w_pop[n]})
               2'b10:   r_count[n] <= r_count[n] + CNTW'(1);
               2'b01:   r_count[n] <= r_count[n] - CNTW'(1);
               default: r_count[n] <= r_count[n];
            endcase
         end
      end
   end

   // Registered output stage: load granted word, or go idle when both empty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_load_en) begin
         if (w_pop_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_grant, r_mem[w_grant][r_rd_ptr[w_grant]]};
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Sticky overflow flags; a new drop beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 2'b00;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (w_drop[n]) begin
               r_ovf[n] <= 1'b1;
            end else if (clr_ovf) begin
               r_ovf[n] <= 1'b0;
            end
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign ovf       = r_ovf;
   assign ch_full   = w_full;

`ifdef RLE_ARB_STATS_EN
   logic [15:0] r_stat_words [2];
   logic [15:0] r_stat_drops [2];

   // Saturating per-channel counters of emitted words and dropped pushes
   always_ff @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         if (rst) begin
            r_stat_words[n] <= 16'h0000;
            r_stat_drops[n] <= 16'h0000;
         end else begin
            if (w_pop[n] && (r_stat_words[n] != 16'hFFFF)) begin
               r_stat_words[n] <= r_stat_words[n] + 16'h0001;
            end
            if (clr_ovf) begin
               r_stat_drops[n] <= w_drop[n] ? 16'h0001 : 16'h0000;
            end else if (w_drop[n] && (r_stat_drops[n] != 16'hFFFF)) begin
               r_stat_drops[n] <= r_stat_drops[n] + 16'h0001;
            end
         end
      end
   end

   assign stat_words0 = r_stat_words[0];
   assign stat_words1 = r_stat_words[1];
   assign stat_drops0 = r_stat_drops[0];
   assign stat_drops1 = r_stat_drops[1];
`endif

endmodule

// File: tb/tb_rle_stream_arbiter.sv
// Directed, self-checking bench for rle_stream_arbiter (default parameters).
// Expected output words are queued in the order they must appear and are
// compared by a monitor whenever a valid/ready handshake is seen.
module tb_rle_stream_arbiter;

   localparam int VW = 9;
   localparam int CW = 8;
   localparam int OW = 1 + VW + CW;

   logic          clk = 1'b0;
   logic          rst;
   logic [VW-1:0] ch0_value, ch1_value;
   logic [CW-1:0] ch0_count, ch1_count;
   logic          ch0_valid, ch1_valid;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    ch_full;
   logic [1:0]    ovf;
   logic          clr_ovf;
`ifdef RLE_ARB_STATS_EN
   logic [15:0]   stat_words0, stat_words1, stat_drops0, stat_drops1;
`endif

   int checks = 0;
   int errors = 0;
   logic [OW-1:0] sb[$];

   always #5 clk = ~clk;

   rle_stream_arbiter #(.DEPTH(4), .VW(VW), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch0_value (ch0_value),
      .ch0_count (ch0_count),
      .ch0_valid (ch0_valid),
      .ch1_value (ch1_value),
      .ch1_count (ch1_count),
      .ch1_valid (ch1_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ch_full   (ch_full),
      .ovf       (ovf),
`ifdef RLE_ARB_STATS_EN
      .stat_words0 (stat_words0),
      .stat_words1 (stat_words1),
      .stat_drops0 (stat_drops0),
      .stat_drops1 (stat_drops1),
`endif
      .clr_ovf   (clr_ovf)
   );

   // Monitor: every handshake must match the head of the expected queue
   always @(negedge clk) begin
      logic [OW-1:0] exp_w;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $error("FAIL unexpected_word observed %h expected none", out_data);
         end else begin
            exp_w = sb.pop_front();
            assert (out_data === exp_w) else begin
               errors++;
               $error("FAIL out_word observed %h expected %h", out_data, exp_w);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OW-1:0] mk(input logic id, input logic [VW-1:0] v, input logic [CW-1:0] c);
      return {id, v, c};
   endfunction

   task automatic idle_inputs();
      ch0_valid = 1'b0;
      ch1_valid = 1'b0;
      clr_ovf   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic drive0(input logic [VW-1:0] v, input logic [CW-1:0] c);
      ch0_value = v;
      ch0_count = c;
      ch0_valid = 1'b1;
   endtask

   task automatic drive1(input logic [VW-1:0] v, input logic [CW-1:0] c);
      ch1_value = v;
      ch1_count = c;
      ch1_valid = 1'b1;
   endtask

   // Wait (bounded) until every expected word has been seen
   task automatic drain(input string tag);
      for (int k = 0; k < 40; k++) begin
         if (sb.size() == 0) break;
         tick();
      end
      chk(tag, sb.size(), 32'd0);
   endtask

   initial begin
      ch0_value = '0; ch0_count = '0;
      ch1_value = '0; ch1_count = '0;
      idle_inputs();
      out_ready = 1'b0;

      // Reset then idle
      do_reset();
      tick();
      chk("reset_valid", out_valid, 32'd0);
      chk("reset_ovf", ovf, 32'd0);
      chk("reset_full", ch_full, 32'd0);

      // Single run on channel 1 (value -5, count 12)
      out_ready = 1'b1;
      drive1(9'h1FB, 8'd12);
      sb.push_back(mk(1'b1, 9'h1FB, 8'd12));
      tick();
      idle_inputs();
      chk("single_valid_early", out_valid, 32'd0);
      tick();
      chk("single_valid", out_valid, 32'd1);
      chk("single_data", out_data, {14'd0, 1'b1, 9'h1FB, 8'd12});
      tick();
      chk("single_valid_drop", out_valid, 32'd0);
      chk("single_sb_empty", sb.size(), 32'd0);

      // Round robin: A0,A1 on ch0 and B0,B1 on ch1, preloaded under stall
      do_reset();
      drive0(9'h011, 8'd1);
      drive1(9'h1F0, 8'd2);
      tick();
      drive0(9'h022, 8'd3);
      drive1(9'h0F0, 8'd4);
      tick();
      idle_inputs();
      sb.push_back(mk(1'b0, 9'h011, 8'd1));
      sb.push_back(mk(1'b1, 9'h1F0, 8'd2));
      sb.push_back(mk(1'b0, 9'h022, 8'd3));
      sb.push_back(mk(1'b1, 9'h0F0, 8'd4));
      tick();
      chk("rr_stall_data", out_data, {14'd0, 1'b0, 9'h011, 8'd1});
      out_ready = 1'b1;
      drain("rr_drain");
      tick();
      chk("rr_idle", out_valid, 32'd0);

      // Backpressure and overflow on channel 0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive0(VW'(9'h040 + i), CW'(8'd10 + i));
         sb.push_back(mk(1'b0, VW'(9'h040 + i), CW'(8'd10 + i)));
         tick();
      end
      chk("bp_full", ch_full, 32'd1);
      chk("bp_no_ovf_yet", ovf, 32'd0);
      drive0(9'h0AA, 8'd99);
      tick();
      idle_inputs();
      chk("bp_ovf", ovf, 32'd1);
      chk("bp_full_hold", ch_full, 32'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("bp_clr_ovf", ovf, 32'd0);
      out_ready = 1'b1;
      drain("bp_drain");
      tick();
      chk("bp_idle", out_valid, 32'd0);
      chk("bp_empty", ch_full, 32'd0);

      // Simultaneous push/pop on a full FIFO
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive0(VW'(9'h100 + i), CW'(8'd20 + i));
         sb.push_back(mk(1'b0, VW'(9'h100 + i), CW'(8'd20 + i)));
         tick();
      end
      chk("pp_full_pre", ch_full, 32'd1);
      out_ready = 1'b1;
      for (int i = 5; i < 8; i++) begin
         drive0(VW'(9'h100 + i), CW'(8'd20 + i));
         sb.push_back(mk(1'b0, VW'(9'h100 + i), CW'(8'd20 + i)));
         tick();
         chk("pp_full_hold", ch_full, 32'd1);
         chk("pp_no_ovf", ovf, 32'd0);
      end
      idle_inputs();
      drain("pp_drain");
      chk("pp_ovf_end", ovf, 32'd0);

      // Reset mid-stream: 3 words queued plus one held at the output
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive0(VW'(9'h0C0 + i), CW'(8'd30 + i));
         tick();
      end
      idle_inputs();
      chk("mid_held_valid", out_valid, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid_after_rst", out_valid, 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      chk("mid_no_stale", out_valid, 32'd0);
      chk("mid_full_clear", ch_full, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
